// File: rtl/cgp_eval_pkg.sv
// Shared types, sizes and helpers for the CGP truth-table evaluation flow.
package cgp_eval_pkg;

   localparam int unsigned NUM_IN  = 7;
   localparam int unsigned NUM_OUT = 2;
   localparam int unsigned NUM_VEC = 2 ** NUM_IN;
   localparam int unsigned ERR_W   = NUM_IN + $clog2(NUM_OUT) + 1;
   localparam int unsigned POP_W   = $clog2(NUM_OUT + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_e;

   function automatic logic [POP_W-1:0] popcount(input logic [NUM_OUT-1:0] v);
      logic [POP_W-1:0] cnt;
      cnt = '0;
      for (int i = 0; i < int'(NUM_OUT); i++) begin
         cnt = cnt + POP_W'(v[i]);
      end
      return cnt;
   endfunction

endpackage

// File: rtl/tt_mismatch_acc.sv
// Per-vector output comparison: Hamming-distance accumulation and first-failure capture.
module tt_mismatch_acc
   import cgp_eval_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               clr_i,
   input  logic               en_i,
   input  logic [NUM_IN-1:0]  pi_vec_i,
   input  logic [NUM_OUT-1:0] cand_po_i,
   input  logic [NUM_OUT-1:0] gold_po_i,
   output logic               mismatch_c,
   output logic [ERR_W-1:0]   err_count_o,
   output logic               fail_seen_o,
   output logic [NUM_IN-1:0]  first_fail_vec_o
);

   logic [NUM_OUT-1:0] diff_c;
   logic [ERR_W-1:0]   err_q, err_d;
   logic               fail_q, fail_d;
   logic [NUM_IN-1:0]  ffv_q, ffv_d;

   assign diff_c     = cand_po_i ^ gold_po_i;
   assign mismatch_c = |diff_c;

   // Clear has priority; otherwise accumulate only while the sweeper enables us.
   always_comb begin
      err_d  = err_q;
      fail_d = fail_q;
      ffv_d  = ffv_q;
      if (clr_i) begin
         err_d  = '0;
         fail_d = 1'b0;
         ffv_d  = '0;
      end else if (en_i) begin
         err_d = err_q + ERR_W'(popcount(diff_c));
         if (mismatch_c && !fail_q) begin
            fail_d = 1'b1;
            ffv_d  = pi_vec_i;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_q  <= '0;
         fail_q <= 1'b0;
         ffv_q  <= '0;
      end else begin
         err_q  <= err_d;
         fail_q <= fail_d;
         ffv_q  <= ffv_d;
      end
   end

   assign err_count_o      = err_q;
   assign fail_seen_o      = fail_q;
   assign first_fail_vec_o = ffv_q;

endmodule

// File: rtl/tt_fitness_sweeper.sv
// Exhaustive truth-table sweeper: walks every input vector and scores the candidate against golden.
module tt_fitness_sweeper
   import cgp_eval_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   output logic [NUM_IN-1:0]  pi_vec,
   input  logic [NUM_OUT-1:0] cand_po,
   input  logic [NUM_OUT-1:0] gold_po,
   output logic               busy,
   output logic               done,
   output logic [ERR_W-1:0]   err_count,
   output logic               perfect,
   output logic               fail_seen,
   output logic [NUM_IN-1:0]  first_fail_vec
);

   localparam logic [NUM_IN-1:0] PI_LAST = NUM_IN'(NUM_VEC - 1);

   state_e            state_q;
   logic [NUM_IN-1:0] pi_vec_q;
   logic              busy_q;
   logic              done_q;
   logic              perfect_q;

   logic acc_clr_c;
   logic acc_en_c;
   logic mismatch_c;
   logic fail_seen_c;

   assign acc_clr_c = (state_q == IDLE) && start && !abort;
   assign acc_en_c  = (state_q == SWEEP) && !abort;

   tt_mismatch_acc u_acc (
      .clk              (clk),
      .rst              (rst),
      .clr_i            (acc_clr_c),
      .en_i             (acc_en_c),
      .pi_vec_i         (pi_vec_q),
      .cand_po_i        (cand_po),
      .gold_po_i        (gold_po),
      .mismatch_c       (mismatch_c),
      .err_count_o      (err_count),
      .fail_seen_o      (fail_seen_c),
      .first_fail_vec_o (first_fail_vec)
   );

   // perfect is resolved on the last SWEEP edge so it already counts the final vector.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         pi_vec_q  <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         perfect_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start && !abort) begin
                  state_q   <= SWEEP;
                  pi_vec_q  <= '0;
                  busy_q    <= 1'b1;
                  perfect_q <= 1'b0;
               end
            end
            SWEEP: begin
               if (abort) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (pi_vec_q == PI_LAST) begin
                  state_q   <= DONE;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  perfect_q <= !(fail_seen_c || mismatch_c);
               end else begin
                  pi_vec_q <= pi_vec_q + NUM_IN'(1);
               end
            end
            DONE: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign pi_vec    = pi_vec_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign perfect   = perfect_q;
   assign fail_seen = fail_seen_c;

endmodule

// File: doc/tt_fitness_sweeper.md
Name: tt_fitness_sweeper

Overview:
- Exhaustive truth-table sweeper for the CGP evaluation flow. It sits directly upstream and downstream of a combinational candidate circuit with 7 inputs and 2 outputs.
- It drives every input vector 0..2^NUM_IN-1 onto the candidate's pi inputs, one per clock.
- On each vector it samples the candidate po outputs against the golden-reference po outputs and accumulates the Hamming-distance error count, which is the fitness.
- It also reports the first failing vector, for debug of evolved circuits.

Parameters:
- NUM_IN, 7, number of primary inputs of the circuit under evaluation.
- NUM_OUT, 2, number of primary outputs compared per vector.
- ERR_W, NUM_IN+$clog2(NUM_OUT)+1, error-counter width; holds the worst case 2^NUM_IN*NUM_OUT without overflow.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a sweep; honoured only in IDLE.
- abort  in  1  terminate a sweep in progress.
- pi_vec  out  NUM_IN  registered input vector driven to both candidate and golden circuits.
- cand_po  in  NUM_OUT  candidate outputs; combinational function of pi_vec.
- gold_po  in  NUM_OUT  golden outputs; combinational function of pi_vec.
- busy  out  1  high in SWEEP.
- done  out  1  one-cycle pulse when a full sweep completes.
- err_count  out  ERR_W  accumulated mismatched output bits.
- perfect  out  1  err_count==0 at completion; valid while done and afterwards.
- fail_seen  out  1  at least one mismatch in the current or last sweep.
- first_fail_vec  out  NUM_IN  pi_vec of the first mismatch; 0 if none.

Behaviour:
- Reset (async, any state): state=IDLE. pi_vec, err_count and first_fail_vec go to 0. busy, done, fail_seen and perfect go to 0.
- States: IDLE, SWEEP, DONE.
- IDLE to SWEEP on start && !abort, registered at that edge:
  - pi_vec=0, err_count=0, fail_seen=0, first_fail_vec=0, perfect=0.
- SWEEP, every edge:
  - err_count += popcount(cand_po ^ gold_po), sampled for the current pi_vec. The candidate and golden circuits settle within one cycle, so there is no extra pipeline stage.
  - If the xor is nonzero and fail_seen==0: first_fail_vec=pi_vec, fail_seen=1.
  - If pi_vec==2^NUM_IN-1: go to DONE and leave pi_vec unchanged. Otherwise pi_vec+1.
- DONE: done=1 for exactly one cycle. perfect=(err_count==0). Then IDLE.
- Latency: the start edge is cycle 0. SWEEP occupies cycles 1..2^NUM_IN. done is high in cycle 2^NUM_IN+1, i.e. 129 for the default parameters.
- abort in SWEEP:
  - Go to IDLE at that edge. No accumulation for that cycle, no done.
  - err_count and fail fields keep their partial values. perfect stays 0.
- abort in DONE: ignored; the done pulse still occurs.
- start while in SWEEP or DONE: ignored.
- start and abort together in IDLE: abort wins, stay IDLE.
- Outputs hold after DONE until the next accepted start.
- pi_vec wraps only via restart. The counter never exceeds 2^NUM_IN-1.
- err_count never saturates; ERR_W is sized for the maximum.
- A mismatch on vector 0 sets first_fail_vec=0 with fail_seen=1. That distinguishes it from "none".

Decomposition:
- Shared package cgp_eval_pkg:
  - state enum {IDLE, SWEEP, DONE};
  - localparam NUM_VEC=2**NUM_IN;
  - function popcount for NUM_OUT-wide vectors.
- One natural sub-module: tt_mismatch_acc. It is the xor/popcount/accumulate/first-fail capture datapath and is enabled by the FSM.
- The top module holds the FSM and the pi_vec counter.

Test Plan:
- Candidate identical to golden (both the con1 benchmark function), start pulse:
  - busy high cycles 1..128, done at cycle 129;
  - err_count=0, perfect=1, fail_seen=0.
- Candidate = golden with po0 inverted:
  - err_count=128, first_fail_vec=0x00, fail_seen=1, perfect=0.
- Candidate = ~golden on both outputs: err_count=256 (9-bit max, no overflow).
- Candidate differs only on po1 when pi_vec==7'h55:
  - err_count=1, first_fail_vec=7'h55, fail_seen=1.
- abort asserted on SWEEP cycle 10 (pi_vec=9):
  - IDLE next cycle, no done;
  - err_count equals the mismatches over vectors 0..8;
  - start on the same cycle as a later abort in IDLE is ignored.
- rst asserted mid-sweep at pi_vec=40:
  - all outputs 0 immediately;
  - a start issued during SWEEP is ignored;
  - a fresh start after reset completes a full 128-vector sweep.
